// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the 32-bit bus datapath: fetches a word through MAR/MDR into IR,
// then walks the per-opcode micro-steps driving bus select, load enables, ALU_Sel, read and incPC.
module control_sequencer #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [31:0] IR_data_out,
   input  logic        mem_ack,
   output logic [31:0] i,
   output logic [31:0] reg_enable,
   output logic [5:0]  ALU_Sel,
   output logic        read,
   output logic        incPC,
   output logic        mem_req,
   output logic        mem_we,
   output logic        busy,
   output logic        halted,
   output logic        illegal_op,
   output logic        mem_err
);

   localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   // Bus-source / load-enable bit positions above the general registers
   localparam logic [4:0] B_HI  = 5'd16;
   localparam logic [4:0] B_LO  = 5'd17;
   localparam logic [4:0] B_ZHI = 5'd18;
   localparam logic [4:0] B_ZLO = 5'd19;
   localparam logic [4:0] B_PC  = 5'd20;
   localparam logic [4:0] B_IR  = 5'd21;
   localparam logic [4:0] B_MDR = 5'd22;
   localparam logic [4:0] B_MAR = 5'd23;
   localparam logic [4:0] B_Y   = 5'd24;

   localparam logic [4:0] OP_ALU_LAST = 5'b01110;
   localparam logic [4:0] OP_MUL      = 5'b01111;
   localparam logic [4:0] OP_DIV      = 5'b10000;
   localparam logic [4:0] OP_LD       = 5'b10001;
   localparam logic [4:0] OP_ST       = 5'b10010;
   localparam logic [4:0] OP_MFHI     = 5'b10011;
   localparam logic [4:0] OP_MFLO     = 5'b10100;
   localparam logic [4:0] OP_NOP      = 5'b11000;
   localparam logic [4:0] OP_HALT     = 5'b11011;

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;

   logic [4:0] op;
   logic [3:0] ra;
   logic [3:0] rb;
   logic [3:0] rc;
   logic       unused_ir_bits;

   assign op = IR_data_out[31:27];
   assign ra = IR_data_out[26:23];
   assign rb = IR_data_out[22:19];
   assign rc = IR_data_out[18:15];
   assign unused_ir_bits = ^IR_data_out[14:0];

   logic is_alu, is_muldiv, is_ld, is_st, is_mfhi, is_mflo, is_nop, is_halt;

   assign is_alu    = (op <= OP_ALU_LAST);
   assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
   assign is_ld     = (op == OP_LD);
   assign is_st     = (op == OP_ST);
   assign is_mfhi   = (op == OP_MFHI);
   assign is_mflo   = (op == OP_MFLO);
   assign is_nop    = (op == OP_NOP);
   assign is_halt   = (op == OP_HALT);

   // Memory-wait steps: instruction fetch, ld data read, st data write
   logic in_wait;
   logic timeout;

   assign in_wait = (state == S_T1) ||
                    ((state == S_T4) && is_ld) ||
                    ((state == S_T5) && is_st);
   assign timeout = in_wait && !mem_ack && (ACK_TIMEOUT != 0) && (wait_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         if (!in_wait || mem_ack || timeout) begin
            wait_cnt <= '0;
         end else if (ACK_TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end

         if (timeout) begin
            mem_err <= 1'b1;
            state   <= S_HALT;
         end else begin
            case (state)
               S_IDLE: if (start) state <= S_T0;
               S_T0:   state <= S_T1;
               S_T1:   if (mem_ack) state <= S_T2;
               S_T2:   state <= S_T3;
               S_T3: begin
                  if (is_halt) begin
                     state <= S_HALT;
                  end else if (is_alu || is_muldiv || is_ld || is_st) begin
                     state <= S_T4;
                  end else begin
                     state <= S_T0;
                  end
               end
               S_T4: begin
                  if (!is_ld || mem_ack) state <= S_T5;
               end
               S_T5: begin
                  if (is_muldiv) begin
                     state <= S_T6;
                  end else if (!is_st || mem_ack) begin
                     state <= S_T0;
                  end
               end
               S_T6:   state <= S_T0;
               S_HALT: state <= S_HALT;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // Outputs decode from state and the live IR: IR loads on the edge that enters T3,
   // so T3 controls cannot be precomputed a cycle early. IDLE decodes to all zeros.
   always_comb begin
      i          = '0;
      reg_enable = '0;
      ALU_Sel    = '0;
      read       = 1'b0;
      incPC      = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      illegal_op = 1'b0;
      busy       = (state != S_IDLE) && (state != S_HALT);
      halted     = (state == S_HALT);

      case (state)
         S_T0: begin
            i[B_PC]           = 1'b1;
            reg_enable[B_MAR] = 1'b1;
            incPC             = 1'b1;
         end
         S_T1: begin
            mem_req           = 1'b1;
            read              = 1'b1;
            reg_enable[B_MDR] = mem_ack;
         end
         S_T2: begin
            i[B_MDR]         = 1'b1;
            reg_enable[B_IR] = 1'b1;
         end
         S_T3: begin
            if (is_alu || is_muldiv) begin
               i[rb]           = 1'b1;
               reg_enable[B_Y] = 1'b1;
            end else if (is_ld || is_st) begin
               i[rb]             = 1'b1;
               reg_enable[B_MAR] = 1'b1;
            end else if (is_mfhi) begin
               i[B_HI]        = 1'b1;
               reg_enable[ra] = 1'b1;
            end else if (is_mflo) begin
               i[B_LO]        = 1'b1;
               reg_enable[ra] = 1'b1;
            end else if (!is_nop && !is_halt) begin
               illegal_op = 1'b1;
            end
         end
         S_T4: begin
            if (is_ld) begin
               mem_req           = 1'b1;
               read              = 1'b1;
               reg_enable[B_MDR] = mem_ack;
            end else if (is_st) begin
               i[ra]             = 1'b1;
               reg_enable[B_MDR] = 1'b1;
            end else begin
               i[rc]             = 1'b1;
               reg_enable[B_ZHI] = 1'b1;
               reg_enable[B_ZLO] = 1'b1;
               ALU_Sel           = {1'b0, op};
            end
         end
         S_T5: begin
            if (is_ld) begin
               i[B_MDR]       = 1'b1;
               reg_enable[ra] = 1'b1;
            end else if (is_st) begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
            end else if (is_muldiv) begin
               i[B_ZLO]         = 1'b1;
               reg_enable[B_LO] = 1'b1;
            end else begin
               i[B_ZLO]       = 1'b1;
               reg_enable[ra] = 1'b1;
            end
         end
         S_T6: begin
            i[B_ZHI]         = 1'b1;
            reg_enable[B_HI] = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a small behavioural datapath and memory responder
// around the sequencer, with per-scenario tasks checking each micro-step.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        start = 1'b0;
   logic        mem_ack = 1'b0;
   logic [31:0] i, reg_enable;
   logic [5:0]  ALU_Sel;
   logic        read, incPC, mem_req, mem_we, busy, halted, illegal_op, mem_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Datapath model state
   logic [31:0] r [16];
   logic [31:0] hi, lo, zh, zl, pc, ir_q, mdr, mar, y;
   logic [31:0] mem [256];
   logic [31:0] bus;
   logic [63:0] alu;

   control_sequencer #(.ACK_TIMEOUT(4)) dut (
      .clk(clk), .clr(clr), .start(start), .IR_data_out(ir_q), .mem_ack(mem_ack),
      .i(i), .reg_enable(reg_enable), .ALU_Sel(ALU_Sel), .read(read), .incPC(incPC),
      .mem_req(mem_req), .mem_we(mem_we), .busy(busy), .halted(halted),
      .illegal_op(illegal_op), .mem_err(mem_err)
   );

   function automatic logic [31:0] b(input int n);
      b = 32'(1) << n;
   endfunction

   always_comb begin
      bus = '0;
      for (int k = 0; k < 16; k++) if (i[k]) bus = r[k];
      if (i[16]) bus = hi;
      if (i[17]) bus = lo;
      if (i[18]) bus = zh;
      if (i[19]) bus = zl;
      if (i[20]) bus = pc;
      if (i[21]) bus = ir_q;
      if (i[22]) bus = mdr;
      if (i[23]) bus = mar;
   end

   always_comb begin
      case (ALU_Sel)
         6'd0:    alu = {32'h0, y + bus};
         6'd15:   alu = {32'h0, y} * {32'h0, bus};
         default: alu = '0;
      endcase
   end

   always @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int k = 0; k < 16; k++) r[k] <= '0;
         r[1] <= 32'hCAFE_F00D;
         r[2] <= 32'h0001_0000;
         r[3] <= 32'h0001_0000;
         hi <= 32'hFFFF_FFFF; lo <= 32'hFFFF_FFFF;
         zh <= '0; zl <= '0; pc <= '0; ir_q <= '0; mdr <= '0; mar <= '0; y <= '0;
         for (int k = 0; k < 256; k++) mem[k] <= '0;
         mem[0] <= 32'h0011_0000;  // add r0,r2,r2
         mem[1] <= 32'h7899_0000;  // mul r1,r3,r2
         mem[2] <= 32'h9090_0000;  // st r1 -> M[r2]
         mem[3] <= 32'h8A10_0000;  // ld r4 <- M[r2]
         mem[4] <= 32'h9A80_0000;  // mfhi r5
         mem[5] <= 32'hF800_0000;  // illegal
         mem[6] <= 32'hC000_0000;  // nop
         mem[7] <= 32'hD800_0000;  // halt
      end else begin
         for (int k = 0; k < 16; k++) if (reg_enable[k]) r[k] <= bus;
         if (reg_enable[16]) hi <= bus;
         if (reg_enable[17]) lo <= bus;
         if (reg_enable[18] && reg_enable[19]) begin
            zh <= alu[63:32];
            zl <= alu[31:0];
         end
         if (reg_enable[20]) pc <= bus;
         else if (incPC) pc <= pc + 32'd1;
         if (reg_enable[21]) ir_q <= bus;
         if (reg_enable[22]) mdr <= read ? mem[mar[7:0]] : bus;
         if (reg_enable[23]) mar <= bus;
         if (reg_enable[24]) y <= bus;
         if (mem_req && mem_we && mem_ack) mem[mar[7:0]] <= mdr;
      end
   end

   // Memory responder: ack after ack_delay request cycles without ack
   bit ack_en = 1'b0;
   int ack_delay = 0;
   int wcnt = 0;

   always @(negedge clk) begin
      if (mem_req && ack_en) begin
         mem_ack = (wcnt == ack_delay);
         wcnt++;
      end else begin
         mem_ack = 1'b0;
         wcnt = 0;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ack(input int limit, input string tag);
      int n = 0;
      while (!mem_ack && n < limit) begin
         step();
         n++;
      end
      checks++;
      if (!mem_ack) begin
         errors++;
         $display("FAIL %s: mem_ack not seen within %0d cycles", tag, n);
      end
   endtask

   // From a T0 sample point, run the fetch and stop at the T3 sample point
   task automatic fetch();
      step();
      wait_ack(10, "fetch_wait");
      step();
      step();
   endtask

   task automatic test_reset();
      logic [77:0] got;
      logic [63:0] e;
      clr = 1'b1; ack_en = 1'b0;
      repeat (2) step();
      clr = 1'b0;
      step();
      got = {i, reg_enable, ALU_Sel, read, incPC, mem_req, mem_we, busy, halted, illegal_op, mem_err};
      checks++;
      if (got !== '0) begin
         errors++; $display("FAIL reset_idle: got %h expected 0", got);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      e = {b(20), b(23)};
      checks++;
      if ({i, reg_enable} !== e || incPC !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL reset_t0: got %h incPC=%b busy=%b expected %h 1 1", {i, reg_enable}, incPC, busy, e);
      end
      step(); step();
      checks++;
      if ({mem_req, read, reg_enable} !== {1'b1, 1'b1, 32'h0}) begin
         errors++; $display("FAIL reset_t1_wait: got req=%b read=%b en=%h expected 1 1 0", mem_req, read, reg_enable);
      end
      #2 clr = 1'b1;
      #1;
      got = {i, reg_enable, ALU_Sel, read, incPC, mem_req, mem_we, busy, halted, illegal_op, mem_err};
      checks++;
      if (got !== '0) begin
         errors++; $display("FAIL reset_async: got %h expected 0", got);
      end
      step();
      clr = 1'b0;
      step(); step();
      checks++;
      if ({busy, halted, mem_req, i} !== 35'h0) begin
         errors++; $display("FAIL reset_stays_idle: got busy=%b halted=%b req=%b i=%h expected 0", busy, halted, mem_req, i);
      end
   endtask

   task automatic test_fetch_add();
      logic [63:0] e;
      ack_en = 1'b1; ack_delay = 3;
      start = 1'b1;
      step();
      start = 1'b0;
      e = {b(20), b(23)};
      checks++;
      if ({i, reg_enable} !== e || incPC !== 1'b1 || mem_req !== 1'b0) begin
         errors++; $display("FAIL add_t0: got %h incPC=%b req=%b expected %h 1 0", {i, reg_enable}, incPC, mem_req, e);
      end
      step();
      checks++;
      if ({mem_req, read, incPC, i, reg_enable} !== {3'b110, 64'h0}) begin
         errors++; $display("FAIL add_t1_first: got req=%b read=%b incPC=%b i=%h en=%h expected 1 1 0 0 0", mem_req, read, incPC, i, reg_enable);
      end
      step(); step();
      checks++;
      if (mem_req !== 1'b1 || reg_enable !== 32'h0) begin
         errors++; $display("FAIL add_t1_hold: got req=%b en=%h expected 1 0", mem_req, reg_enable);
      end
      step();
      checks++;
      if (reg_enable !== b(22) || mem_req !== 1'b1 || read !== 1'b1) begin
         errors++; $display("FAIL add_t1_ack: got en=%h req=%b read=%b expected %h 1 1", reg_enable, mem_req, read, b(22));
      end
      step();
      e = {b(22), b(21)};
      checks++;
      if ({i, reg_enable} !== e || mem_req !== 1'b0 || incPC !== 1'b0) begin
         errors++; $display("FAIL add_t2: got %h req=%b incPC=%b expected %h 0 0", {i, reg_enable}, mem_req, incPC, e);
      end
      step();
      e = {b(2), b(24)};
      checks++;
      if ({i, reg_enable} !== e) begin
         errors++; $display("FAIL add_t3: got %h expected %h", {i, reg_enable}, e);
      end
      step();
      e = {b(2), b(18) | b(19)};
      checks++;
      if ({i, reg_enable} !== e || ALU_Sel !== 6'd0) begin
         errors++; $display("FAIL add_t4: got %h alu=%0d expected %h 0", {i, reg_enable}, ALU_Sel, e);
      end
      step();
      e = {b(19), b(0)};
      checks++;
      if ({i, reg_enable} !== e) begin
         errors++; $display("FAIL add_t5: got %h expected %h", {i, reg_enable}, e);
      end
      step();
      checks++;
      if (r[0] !== 32'h0002_0000 || pc !== 32'd1 || i !== b(20)) begin
         errors++; $display("FAIL add_result: got r0=%h pc=%h i=%h expected 00020000 00000001 %h", r[0], pc, i, b(20));
      end
   endtask

   task automatic test_mul();
      logic [63:0] e;
      ack_delay = 1;
      fetch();
      e = {b(3), b(24)};
      checks++;
      if ({i, reg_enable} !== e) begin
         errors++; $display("FAIL mul_t3: got %h expected %h", {i, reg_enable}, e);
      end
      step();
      e = {b(2), b(18) | b(19)};
      checks++;
      if ({i, reg_enable} !== e || ALU_Sel !== 6'd15) begin
         errors++; $display("FAIL mul_t4: got %h alu=%0d expected %h 15", {i, reg_enable}, ALU_Sel, e);
      end
      step();
      e = {b(19), b(17)};
      checks++;
      if ({i, reg_enable} !== e) begin
         errors++; $display("FAIL mul_t5: got %h expected %h", {i, reg_enable}, e);
      end
      step();
      e = {b(18), b(16)};
      checks++;
      if ({i, reg_enable} !== e || lo !== 32'h0 || hi !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL mul_t6: got %h lo=%h hi=%h expected %h 0 ffffffff", {i, reg_enable}, lo, hi, e);
      end
      step();
      checks++;
      if (hi !== 32'h1 || lo !== 32'h0) begin
         errors++; $display("FAIL mul_result: got hi=%h lo=%h expected 1 0", hi, lo);
      end
   endtask

   task automatic test_st_ld();
      logic [63:0] e;
      fetch();
      e = {b(2), b(23)};
      checks++;
      if ({i, reg_enable} !== e) begin
         errors++; $display("FAIL st_t3: got %h expected %h", {i, reg_enable}, e);
      end
      step();
      e = {b(1), b(22)};
      checks++;
      if ({i, reg_enable} !== e || read !== 1'b0 || mem_req !== 1'b0) begin
         errors++; $display("FAIL st_t4: got %h read=%b req=%b expected %h 0 0", {i, reg_enable}, read, mem_req, e);
      end
      step();
      checks++;
      if ({mem_req, mem_we, read} !== 3'b110 || {i, reg_enable} !== 64'h0) begin
         errors++; $display("FAIL st_t5: got req=%b we=%b read=%b bus=%h expected 1 1 0 0", mem_req, mem_we, read, {i, reg_enable});
      end
      wait_ack(8, "st_wait");
      step();
      checks++;
      if (mem[0] !== 32'hCAFE_F00D || mem_we !== 1'b0) begin
         errors++; $display("FAIL st_result: got mem=%h we=%b expected cafef00d 0", mem[0], mem_we);
      end
      fetch();
      checks++;
      if ({i, reg_enable} !== {b(2), b(23)}) begin
         errors++; $display("FAIL ld_t3: got %h expected %h", {i, reg_enable}, {b(2), b(23)});
      end
      step();
      checks++;
      if ({mem_req, read, mem_we} !== 3'b110 || reg_enable !== 32'h0) begin
         errors++; $display("FAIL ld_t4: got req=%b read=%b we=%b en=%h expected 1 1 0 0", mem_req, read, mem_we, reg_enable);
      end
      wait_ack(8, "ld_wait");
      checks++;
      if (reg_enable !== b(22) || mem_we !== 1'b0) begin
         errors++; $display("FAIL ld_ack: got en=%h we=%b expected %h 0", reg_enable, mem_we, b(22));
      end
      step();
      e = {b(22), b(4)};
      checks++;
      if ({i, reg_enable} !== e) begin
         errors++; $display("FAIL ld_t5: got %h expected %h", {i, reg_enable}, e);
      end
      step();
      checks++;
      if (r[4] !== 32'hCAFE_F00D) begin
         errors++; $display("FAIL ld_result: got r4=%h expected cafef00d", r[4]);
      end
   endtask

   task automatic test_mfhi();
      fetch();
      checks++;
      if ({i, reg_enable} !== {b(16), b(5)}) begin
         errors++; $display("FAIL mfhi_t3: got %h expected %h", {i, reg_enable}, {b(16), b(5)});
      end
      step();
      checks++;
      if (r[5] !== 32'h1 || i !== b(20)) begin
         errors++; $display("FAIL mfhi_result: got r5=%h i=%h expected 1 %h", r[5], i, b(20));
      end
   endtask

   task automatic test_illegal_nop();
      fetch();
      checks++;
      if ({illegal_op, busy} !== 2'b11 || {i, reg_enable} !== 64'h0) begin
         errors++; $display("FAIL illegal_t3: got ill=%b busy=%b bus=%h expected 1 1 0", illegal_op, busy, {i, reg_enable});
      end
      step();
      checks++;
      if (illegal_op !== 1'b0 || {i, reg_enable} !== {b(20), b(23)}) begin
         errors++; $display("FAIL illegal_next: got ill=%b bus=%h expected 0 %h", illegal_op, {i, reg_enable}, {b(20), b(23)});
      end
      fetch();
      checks++;
      if ({illegal_op, busy} !== 2'b01 || {i, reg_enable} !== 64'h0) begin
         errors++; $display("FAIL nop_t3: got ill=%b busy=%b bus=%h expected 0 1 0", illegal_op, busy, {i, reg_enable});
      end
      step();
      checks++;
      if (i !== b(20)) begin
         errors++; $display("FAIL nop_next: got i=%h expected %h", i, b(20));
      end
   endtask

   task automatic test_halt();
      fetch();
      checks++;
      if ({halted, busy} !== 2'b01 || {i, reg_enable} !== 64'h0) begin
         errors++; $display("FAIL halt_t3: got halted=%b busy=%b bus=%h expected 0 1 0", halted, busy, {i, reg_enable});
      end
      step();
      checks++;
      if ({halted, busy, mem_req} !== 3'b100 || {i, reg_enable} !== 64'h0) begin
         errors++; $display("FAIL halt_enter: got halted=%b busy=%b req=%b bus=%h expected 1 0 0 0", halted, busy, mem_req, {i, reg_enable});
      end
      start = 1'b1;
      step(); step();
      start = 1'b0;
      checks++;
      if ({halted, busy} !== 2'b10) begin
         errors++; $display("FAIL halt_hold: got halted=%b busy=%b expected 1 0", halted, busy);
      end
   endtask

   task automatic test_timeout();
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();
      checks++;
      if ({mem_err, halted, busy} !== 3'b000) begin
         errors++; $display("FAIL timeout_pre: got err=%b halted=%b busy=%b expected 0 0 0", mem_err, halted, busy);
      end
      ack_en = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      checks++;
      if ({mem_req, mem_err, halted} !== 3'b100 || reg_enable !== 32'h0) begin
         errors++; $display("FAIL timeout_last_wait: got req=%b err=%b halted=%b en=%h expected 1 0 0 0", mem_req, mem_err, halted, reg_enable);
      end
      step();
      checks++;
      if ({mem_err, halted, busy, mem_req} !== 4'b1100) begin
         errors++; $display("FAIL timeout_halt: got err=%b halted=%b busy=%b req=%b expected 1 1 0 0", mem_err, halted, busy, mem_req);
      end
      step(); step();
      checks++;
      if (mem_err !== 1'b1) begin
         errors++; $display("FAIL mem_err_sticky: got %b expected 1", mem_err);
      end
      clr = 1'b1;
      #1;
      checks++;
      if ({mem_err, halted} !== 2'b00) begin
         errors++; $display("FAIL mem_err_clr: got err=%b halted=%b expected 0 0", mem_err, halted);
      end
      step();
      clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fetch_add();
      test_mul();
      test_st_ld();
      test_mfhi();
      test_illegal_nop();
      test_halt();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
